dwc_upconv_wcmd_hold_buf: RTL

Parametrised multi-entry hold buffer for the up-converter write-channel command path. It pulls write-command descriptors from a first-word-fall-through command FIFO and precomputes the derived decode fields (size one-hot, masked address, wrap qualifiers) at push time. It presents the oldest decoded entry to the write-command FIFO write controller. It replaces the single-entry hold register, adding configurable depth, occupancy reporting, and a synchronous flush.

---
 rtl/dwc_upconv_pkg.sv | 61 ++++++
 rtl/dwc_hold_fifo_ctrl.sv | 71 +++++++
 rtl/dwc_upconv_wcmd_hold_buf.sv | 112 +++++++++++
 3 files changed

// File: rtl/dwc_upconv_pkg.sv
// Shared types and decode for the up-converter command hold buffers.
// The decoded-entry struct is sized by the package constants below.
package dwc_upconv_pkg;

    localparam int unsigned DWC_DATA_WIDTH_OUT = 64;
    localparam int unsigned DWC_ADDR_WIDTH     = 6;
    localparam int unsigned DWC_BOUND_WIDTH    = 5;
    localparam int unsigned DWC_LEN_WIDTH      = 8;

    // Raw descriptor fields followed by the fields derived at push time.
    typedef struct packed {
        logic [DWC_BOUND_WIDTH-1:0] to_boundary;
        logic [DWC_ADDR_WIDTH-1:0]  addr;
        logic [2:0]                 size;
        logic [DWC_LEN_WIDTH-1:0]   wlen_mst;
        logic                       extend_tx;
        logic                       wrap_flag;
        logic                       fixed_flag;
        logic [7:0]                 size_shifted;
        logic [DWC_ADDR_WIDTH-1:0]  mask_addr;
        logic                       aligned_wrap;
        logic                       second_wrap_burst;
        logic                       extend_wrap;
    } entry_t;

    localparam int unsigned ENTRY_W = $bits(entry_t);

    // Builds a decoded entry; width_out_bytes is the downstream beat size in bytes.
    function automatic entry_t decode_entry(
        input logic [DWC_BOUND_WIDTH-1:0] to_boundary,
        input logic [DWC_ADDR_WIDTH-1:0]  addr,
        input logic [2:0]                 size,
        input logic [DWC_LEN_WIDTH-1:0]   wlen_mst,
        input logic                       extend_tx,
        input logic                       wrap_flag,
        input logic                       fixed_flag,
        input int unsigned                width_out_bytes
    );
        entry_t                   e;
        logic [31:0]              mask_full;
        logic [DWC_LEN_WIDTH-1:0] bound_ext;
        e             = '0;
        e.to_boundary = to_boundary;
        e.addr        = addr;
        e.size        = size;
        e.wlen_mst    = wlen_mst;
        e.extend_tx   = extend_tx;
        e.wrap_flag   = wrap_flag;
        e.fixed_flag  = fixed_flag;
        e.size_shifted = 8'(1) << size;
        // Byte-lane bits of the beat that sit above the transfer size.
        mask_full   = (width_out_bytes - 32'd1) & ~((32'd1 << size) - 32'd1);
        e.mask_addr = mask_full[DWC_ADDR_WIDTH-1:0];
        bound_ext   = DWC_LEN_WIDTH'(to_boundary);
        e.aligned_wrap      = (bound_ext == wlen_mst);
        e.second_wrap_burst = wrap_flag & ~extend_tx & ~e.aligned_wrap;
        e.extend_wrap       = wrap_flag & extend_tx;
        return e;
    endfunction

endpackage

// File: rtl/dwc_hold_fifo_ctrl.sv
// Pointer/occupancy control for a small hold FIFO fed from an FWFT source.
module dwc_hold_fifo_ctrl #(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             src_empty_i,
    input  logic             get_next_i,
    output logic             push_o,
    output logic [PTR_W-1:0] wr_ptr_o,
    output logic [PTR_W-1:0] rd_ptr_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Status, handshake and next-state; flush overrides push and pop.
    always_comb begin
        empty_o  = (count_q == '0);
        full_o   = (count_q == CNT_W'(DEPTH));
        pop      = get_next_i & ~empty_o;
        // A pop frees the slot this cycle, so a full buffer can still accept.
        push_o   = ~rst_i & ~src_empty_i & ~flush_i & (~full_o | pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_o) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)    rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push_o, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_ptr_o = wr_ptr_q;
    assign rd_ptr_o = rd_ptr_q;
    assign count_o  = count_q;

endmodule

// File: rtl/dwc_upconv_wcmd_hold_buf.sv
// Multi-entry hold buffer for up-converter write commands. Descriptors are
// decoded on the way in so the head entry presents ready-to-use fields.
module dwc_upconv_wcmd_hold_buf
    import dwc_upconv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_OUT = DWC_DATA_WIDTH_OUT,
    parameter int unsigned ADDR_WIDTH     = DWC_ADDR_WIDTH,
    parameter int unsigned BOUND_WIDTH    = DWC_BOUND_WIDTH,
    parameter int unsigned LEN_WIDTH      = DWC_LEN_WIDTH,
    parameter int unsigned DEPTH          = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   src_fifo_empty,
    output logic                   src_fifo_rd_en,
    input  logic                   get_next,
    output logic                   buf_empty,
    output logic                   buf_full,
    output logic [CNT_W-1:0]       buf_count,
    input  logic [BOUND_WIDTH-1:0] to_boundary,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [2:0]             size,
    input  logic [LEN_WIDTH-1:0]   wlen_mst,
    input  logic                   extend_tx,
    input  logic                   wrap_flag,
    input  logic                   fixed_flag,
    output logic [BOUND_WIDTH-1:0] to_boundary_out,
    output logic [ADDR_WIDTH-1:0]  addr_out,
    output logic [2:0]             size_out,
    output logic [LEN_WIDTH-1:0]   wlen_mst_out,
    output logic                   extend_tx_out,
    output logic                   wrap_flag_out,
    output logic                   fixed_flag_out,
    output logic [7:0]             size_shifted_out,
    output logic [ADDR_WIDTH-1:0]  mask_addr_out,
    output logic                   aligned_wrap_out,
    output logic                   second_wrap_burst_out,
    output logic                   extend_wrap_out
);

    localparam int unsigned WIDTH_OUT_BYTES = DATA_WIDTH_OUT / 8;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    entry_t           new_entry;
    entry_t           head;
    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];

    dwc_hold_fifo_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .src_empty_i (src_fifo_empty),
        .get_next_i  (get_next),
        .push_o      (push),
        .wr_ptr_o    (wr_ptr),
        .rd_ptr_o    (rd_ptr),
        .empty_o     (buf_empty),
        .full_o      (buf_full),
        .count_o     (buf_count)
    );

    assign src_fifo_rd_en = push;

    // Decode the incoming descriptor and stage it into the write slot.
    always_comb begin
        new_entry = decode_entry(to_boundary, addr, size, wlen_mst, extend_tx, wrap_flag,
                                 fixed_flag, WIDTH_OUT_BYTES);
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push) mem_d[wr_ptr] = new_entry;
    end

    // Entry storage; flush leaves contents in place, only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Head outputs come straight from storage, never from the inputs.
    always_comb begin
        head                  = mem_q[rd_ptr];
        to_boundary_out       = head.to_boundary;
        addr_out              = head.addr;
        size_out              = head.size;
        wlen_mst_out          = head.wlen_mst;
        extend_tx_out         = head.extend_tx;
        wrap_flag_out         = head.wrap_flag;
        fixed_flag_out        = head.fixed_flag;
        size_shifted_out      = head.size_shifted;
        mask_addr_out         = head.mask_addr;
        aligned_wrap_out      = head.aligned_wrap;
        second_wrap_burst_out = head.second_wrap_burst;
        extend_wrap_out       = head.extend_wrap;
    end

endmodule
